// File: rtl/spi_fpga_pkg.sv
// rtl/spi_fpga_pkg.sv - shared types and defaults for the SPI FPGA master/slave glue.
package spi_fpga_pkg;

  localparam int PACK_LENGTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAUNCH,
    XFER,
    GAP,
    DONE
  } seq_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - synchronous FIFO with full/empty flags, head word visible on rdata_o.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so equal indices can mean either full or empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_master_burst_sequencer.sv
// rtl/spi_master_burst_sequencer.sv - buffers TX packs and launches SPI_FPGA_MASTER once per pack of a burst.
module spi_master_burst_sequencer
  import spi_fpga_pkg::*;
#(
  parameter int PACK_LENGTH    = PACK_LENGTH_DEF,
  parameter int FIFO_DEPTH     = 16,
  parameter int BURST_LEN_W    = 5,
  parameter int INTER_PACK_GAP = 4
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET_N,
  input  logic [PACK_LENGTH-1:0] IN_WR_DATA,
  input  logic                   IN_WR_VALID,
  output logic                   OUT_WR_READY,
  input  logic                   IN_BURST_START,
  input  logic [BURST_LEN_W-1:0] IN_BURST_LEN,
  output logic                   OUT_BUSY,
  output logic                   OUT_LAUNCH,
  output logic [PACK_LENGTH-1:0] OUT_MASTER_DATA,
  input  logic                   IN_MASTER_CS,
  input  logic                   IN_MASTER_ACTION_DONE,
  input  logic [PACK_LENGTH-1:0] IN_MASTER_RECEIVE_DATA,
  output logic [PACK_LENGTH-1:0] OUT_RX_DATA,
  output logic                   OUT_RX_VALID,
  output logic                   OUT_BURST_DONE,
  output logic                   OUT_UNDERRUN
);

  localparam int GAP_W = $clog2(INTER_PACK_GAP + 1);

  seq_state_e             state_q, state_d;
  logic [BURST_LEN_W-1:0] remaining_q, remaining_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [PACK_LENGTH-1:0] master_data_q, master_data_d;
  logic [PACK_LENGTH-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   burst_done_q;
  logic                   done_prev_q;
  logic                   rdy_en_q;
  logic                   done_rise;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PACK_LENGTH-1:0] fifo_rdata;

  spi_sync_fifo #(
    .WIDTH (PACK_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (IN_CLOCK),
    .rst_ni  (IN_RESET_N),
    .push_i  (fifo_push),
    .wdata_i (IN_WR_DATA),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready is held low until the first clock after reset so writers never race the reset release.
  assign OUT_WR_READY    = rdy_en_q && !fifo_full;
  assign fifo_push       = IN_WR_VALID && OUT_WR_READY;
  assign OUT_LAUNCH      = (state_q == LAUNCH);
  assign OUT_BUSY        = (state_q != IDLE);
  assign OUT_MASTER_DATA = master_data_q;
  assign OUT_RX_DATA     = rx_data_q;
  assign OUT_RX_VALID    = rx_valid_q;
  assign OUT_BURST_DONE  = burst_done_q;
  assign OUT_UNDERRUN    = underrun_q;
  assign done_rise       = IN_MASTER_ACTION_DONE && !done_prev_q;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    gap_cnt_d     = gap_cnt_q;
    master_data_d = master_data_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    underrun_d    = 1'b0;
    fifo_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (IN_BURST_START) begin
          remaining_d = IN_BURST_LEN;
          state_d     = (IN_BURST_LEN == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (fifo_empty) begin
          underrun_d  = 1'b1;
          remaining_d = '0;
          state_d     = IDLE;
        end else begin
          fifo_pop      = 1'b1;
          master_data_d = fifo_rdata;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!IN_MASTER_CS) state_d = XFER;
      end
      XFER: begin
        if (done_rise) begin
          rx_data_d  = IN_MASTER_RECEIVE_DATA;
          rx_valid_d = 1'b1;
          if (remaining_q != '0) remaining_d = remaining_q - BURST_LEN_W'(1);
          gap_cnt_d  = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(INTER_PACK_GAP - 1)) begin
          state_d = (remaining_q != '0) ? FETCH : DONE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      gap_cnt_q     <= '0;
      master_data_q <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      burst_done_q  <= 1'b0;
      done_prev_q   <= 1'b0;
      rdy_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      gap_cnt_q     <= gap_cnt_d;
      master_data_q <= master_data_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      underrun_q    <= underrun_d;
      burst_done_q  <= (state_q == DONE);
      done_prev_q   <= IN_MASTER_ACTION_DONE;
      rdy_en_q      <= 1'b1;
    end
  end

endmodule
